// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS load/store unit: primary opcodes, FSM
// state encoding and small decode helpers.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } lsu_state_t;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // All legal stores share opcode bit 3; loads have it clear.
  function automatic logic op_is_store(input logic [5:0] op);
    return op[3];
  endfunction

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_lsu_if.sv
// Bus bundles for the load/store unit: execute-side request/response and
// data-memory side. The unit is the slave of the request bus and the master
// of the memory bus.
interface mips_lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic [5:0]  opcode;
  logic [31:0] base;
  logic [15:0] offset;
  logic [31:0] store_data;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  modport master (
    output req_valid, opcode, base, offset, store_data,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, opcode, base, offset, store_data,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

interface mips_lsu_mem_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mips_lsu_align.sv
// Combinational lane logic: byte enables and store-data replication on the
// way out, lane extraction with sign/zero extension on the way back.
module mips_lsu_align
  import mips_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [1:0]  ea_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    case (ea_lo)
      2'd0:    rbyte = rdata[7:0];
      2'd1:    rbyte = rdata[15:8];
      2'd2:    rbyte = rdata[23:16];
      default: rbyte = rdata[31:24];
    endcase
    rhalf = ea_lo[1] ? rdata[31:16] : rdata[15:0];
  end

  always_comb begin
    be         = 4'b0000;
    wdata      = 32'h0;
    load_data  = 32'h0;
    misaligned = 1'b0;
    case (opcode)
      OP_LB: begin
        be        = 4'b1111;
        load_data = {{24{rbyte[7]}}, rbyte};
      end
      OP_LBU: begin
        be        = 4'b1111;
        load_data = {24'h0, rbyte};
      end
      OP_LH: begin
        be         = 4'b1111;
        load_data  = {{16{rhalf[15]}}, rhalf};
        misaligned = ea_lo[0];
      end
      OP_LHU: begin
        be         = 4'b1111;
        load_data  = {16'h0, rhalf};
        misaligned = ea_lo[0];
      end
      OP_LW: begin
        be         = 4'b1111;
        load_data  = rdata;
        misaligned = |ea_lo;
      end
      OP_SB: begin
        be    = 4'b0001 << ea_lo;
        wdata = {4{store_data[7:0]}};
      end
      OP_SH: begin
        be         = ea_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        misaligned = ea_lo[0];
      end
      OP_SW: begin
        be         = 4'b1111;
        wdata      = store_data;
        misaligned = |ea_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// MIPS load/store unit: registers one request, issues a byte-enabled word
// access to data memory, and returns formatted load data or an error.
//
// state   | meaning
// IDLE    | ready for a request; registers it on accept
// WAIT    | mem_req held until mem_ack or timeout
// RESP    | one-cycle rsp_valid strobe
module mips_lsu
  import mips_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  mips_lsu_req_if.slave   req,
  mips_lsu_mem_if.master  mem
);

  localparam int             CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0]  TC_LOAD = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam bit             TO_EN   = (TIMEOUT > 0);

  lsu_state_t state, state_nx;

  logic [31:0]   ea;
  logic [31:0]   ea_q;
  logic [5:0]    op_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic          we_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   rsp_data_q;
  logic          rsp_err_q;

  logic        in_wait;
  logic        accept;
  logic        req_err;
  logic        tmo_hit;
  logic [5:0]  al_op;
  logic [1:0]  al_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic        al_misaligned;

  assign ea      = req.base + sext16(req.offset);
  assign in_wait = (state == ST_WAIT);
  assign accept  = req.req_valid && (state == ST_IDLE);

  // One aligner serves both directions: the incoming request in IDLE and the
  // registered request while waiting for read data.
  assign al_op = in_wait ? op_q       : req.opcode;
  assign al_lo = in_wait ? ea_q[1:0]  : ea[1:0];

  mips_lsu_align u_align (
    .opcode     (al_op),
    .ea_lo      (al_lo),
    .store_data (req.store_data),
    .rdata      (mem.mem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_data  (al_load),
    .misaligned (al_misaligned)
  );

  assign req_err = !op_legal(req.opcode) || al_misaligned;
  assign tmo_hit = TO_EN && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept) state_nx = req_err ? ST_RESP : ST_WAIT;
      ST_WAIT: if (mem.mem_ack || tmo_hit) state_nx = ST_RESP;
      ST_RESP: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ea_q       <= 32'h0;
      op_q       <= 6'h0;
      be_q       <= 4'h0;
      wdata_q    <= 32'h0;
      we_q       <= 1'b0;
      cnt_q      <= '0;
      rsp_data_q <= 32'h0;
      rsp_err_q  <= 1'b0;
    end else if (accept) begin
      ea_q       <= ea;
      op_q       <= req.opcode;
      be_q       <= al_be;
      wdata_q    <= al_wdata;
      we_q       <= op_is_store(req.opcode);
      cnt_q      <= TC_LOAD;
      rsp_data_q <= ea;
      rsp_err_q  <= req_err;
    end else if (in_wait) begin
      // Ack wins over a timeout landing on the same edge.
      if (mem.mem_ack) begin
        rsp_data_q <= we_q ? 32'h0 : al_load;
        rsp_err_q  <= 1'b0;
      end else if (tmo_hit) begin
        rsp_data_q <= ea_q;
        rsp_err_q  <= 1'b1;
      end else if (TO_EN) begin
        cnt_q <= cnt_q - CW'(1);
      end
    end
  end

  assign req.req_ready = (state == ST_IDLE);
  assign req.rsp_valid = (state == ST_RESP);
  assign req.rsp_data  = (state == ST_RESP) ? rsp_data_q : 32'h0;
  assign req.rsp_err   = (state == ST_RESP) && rsp_err_q;

  assign mem.mem_req   = in_wait;
  assign mem.mem_we    = in_wait && we_q;
  assign mem.mem_addr  = in_wait ? {ea_q[31:2], 2'b00} : 32'h0;
  assign mem.mem_be    = in_wait ? be_q    : 4'h0;
  assign mem.mem_wdata = in_wait ? wdata_q : 32'h0;

endmodule

// File: tb/tb_mips_lsu.sv
// Scoreboard bench for mips_lsu: directed scenarios plus randomized traffic
// against a byte-level memory and reference model.
module tb_mips_lsu;
  import mips_pkg::*;

  localparam int TMO = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mips_lsu_req_if rq();
  mips_lsu_mem_if mm();

  mips_lsu #(.TIMEOUT(TMO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (rq),
    .mem   (mm)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        we;
    int          lat;
    bit          noack;
    bit          abort;
  } txn_t;

  rsp_t exp_rsp[$];
  txn_t exp_txn[$];
  logic [31:0] ref_mem [int unsigned];
  logic [31:0] mem_arr [int unsigned];
  logic [5:0]  ops [8] = '{OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_word(input int unsigned w);
    return (w * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  function automatic logic [31:0] ref_rd(input int unsigned w);
    return ref_mem.exists(w) ? ref_mem[w] : init_word(w);
  endfunction

  function automatic logic [31:0] mem_rd(input int unsigned w);
    return mem_arr.exists(w) ? mem_arr[w] : init_word(w);
  endfunction

  task automatic preload(input logic [31:0] addr, input logic [31:0] v);
    ref_mem[addr >> 2] = v;
    mem_arr[addr >> 2] = v;
  endtask

  // Reference model: derives the expected memory transaction and response
  // from the architectural load/store rules.
  task automatic model(input logic [5:0] op, input logic [31:0] base, input logic [15:0] off,
                       input logic [31:0] sd, input int lat, input bit noack, input bit abort);
    logic [31:0] ea;
    int unsigned w;
    int          k;
    bit          legal, is_ld, sgn, bad;
    int          size;
    logic [31:0] word, v, ld;
    txn_t        t;
    ea = base + {{16{off[15]}}, off};
    w  = ea >> 2;
    k  = int'(ea[1:0]);
    legal = 1; is_ld = 1; sgn = 0; size = 4;
    case (op)
      OP_LB:  begin size = 1; sgn = 1; end
      OP_LBU: size = 1;
      OP_LH:  begin size = 2; sgn = 1; end
      OP_LHU: size = 2;
      OP_LW:  size = 4;
      OP_SB:  begin size = 1; is_ld = 0; end
      OP_SH:  begin size = 2; is_ld = 0; end
      OP_SW:  begin size = 4; is_ld = 0; end
      default: legal = 0;
    endcase
    bad = !legal || (k % size != 0);
    if (bad) begin
      exp_rsp.push_back('{data: ea, err: 1'b1});
      return;
    end
    t.addr = ea & 32'hFFFF_FFFC;
    t.we = !is_ld; t.lat = lat; t.noack = noack; t.abort = abort;
    ld = 32'h0;
    if (is_ld) begin
      t.be = 4'hF;
      t.wdata = 32'h0;
      word = ref_rd(w);
      v = word >> (8 * k);
      if (size == 1)      ld = sgn ? 32'($signed(v[7:0]))  : 32'(v[7:0]);
      else if (size == 2) ld = sgn ? 32'($signed(v[15:0])) : 32'(v[15:0]);
      else                ld = v;
    end else begin
      t.be = 4'(((1 << size) - 1) << k);
      if (size == 1)      t.wdata = sd[7:0]  * 32'h0101_0101;
      else if (size == 2) t.wdata = sd[15:0] * 32'h0001_0001;
      else                t.wdata = sd;
      if (!noack && !abort) begin
        word = ref_rd(w);
        for (int i = 0; i < 4; i++)
          if (t.be[i]) word[8*i +: 8] = t.wdata[8*i +: 8];
        ref_mem[w] = word;
      end
    end
    exp_txn.push_back(t);
    if (!abort) begin
      if (noack) exp_rsp.push_back('{data: ea, err: 1'b1});
      else       exp_rsp.push_back('{data: ld, err: 1'b0});
    end
  endtask

  task automatic send(input logic [5:0] op, input logic [31:0] base, input logic [15:0] off,
                      input logic [31:0] sd, input int lat, input bit noack, input bit abort);
    int guard;
    @(negedge clk);
    rq.req_valid = 1'b1; rq.opcode = op; rq.base = base; rq.offset = off; rq.store_data = sd;
    guard = 0;
    while (rq.req_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      chk("req_ready_timeout", {31'h0, rq.req_ready}, 32'h1);
      rq.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    model(op, base, off, sd, lat, noack, abort);
    #1 rq.req_valid = 1'b0;
  endtask

  // Memory responder: checks each issued access and acks after its latency.
  initial begin : responder
    txn_t cur;
    bit busy;
    int cyc;
    logic [31:0] wv;
    int unsigned w;
    mm.mem_ack = 1'b0;
    mm.mem_rdata = 32'h0;
    busy = 0; cyc = 0;
    cur = '{addr: 0, be: 0, wdata: 0, we: 0, lat: 0, noack: 1, abort: 1};
    forever begin
      @(negedge clk);
      mm.mem_ack = 1'b0;
      if (mm.mem_req === 1'b1) begin
        if (!busy) begin
          busy = 1; cyc = 0;
          if (exp_txn.size() == 0) begin
            chk("unexpected_mem_req", 32'h1, 32'h0);
            cur = '{addr: 0, be: 0, wdata: 0, we: 0, lat: 0, noack: 1, abort: 1};
          end else begin
            cur = exp_txn.pop_front();
            chk("mem_addr", mm.mem_addr, cur.addr);
            chk("mem_be", {28'h0, mm.mem_be}, {28'h0, cur.be});
            chk("mem_we", {31'h0, mm.mem_we}, {31'h0, cur.we});
            if (cur.we) chk("mem_wdata", mm.mem_wdata, cur.wdata);
          end
        end
        cyc++;
        if (!cur.noack && cyc == cur.lat) begin
          mm.mem_ack = 1'b1;
          w = mm.mem_addr >> 2;
          if (cur.we) begin
            wv = mem_rd(w);
            for (int i = 0; i < 4; i++)
              if (mm.mem_be[i]) wv[8*i +: 8] = mm.mem_wdata[8*i +: 8];
            mem_arr[w] = wv;
          end else begin
            mm.mem_rdata = mem_rd(w);
          end
        end
      end else if (busy) begin
        busy = 0;
        if (!cur.abort) chk("mem_req_cycles", cyc, cur.noack ? TMO : cur.lat);
        // Stray ack after a timeout must not disturb the unit.
        if (cur.noack && !cur.abort) begin
          mm.mem_ack = 1'b1;
          mm.mem_rdata = $urandom;
        end
      end
    end
  end

  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rq.rsp_valid === 1'b1) begin
        if (exp_rsp.size() == 0) begin
          chk("unexpected_rsp", rq.rsp_data, 32'hXXXX_XXXX);
        end else begin
          e = exp_rsp.pop_front();
          chk("rsp_data", rq.rsp_data, e.data);
          chk("rsp_err", {31'h0, rq.rsp_err}, {31'h0, e.err});
        end
      end
    end
  end

  initial begin : stim
    logic [5:0]  op;
    logic [31:0] base;
    logic [15:0] off;
    int guard;
    rq.req_valid = 1'b0; rq.opcode = 6'h0; rq.base = 32'h0; rq.offset = 16'h0; rq.store_data = 32'h0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", {31'h0, rq.req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, rq.rsp_valid}, 32'h0);
    chk("rst_rsp_data",  rq.rsp_data, 32'h0);
    chk("rst_rsp_err",   {31'h0, rq.rsp_err}, 32'h0);
    chk("rst_mem_req",   {31'h0, mm.mem_req}, 32'h0);
    chk("rst_mem_we",    {31'h0, mm.mem_we}, 32'h0);
    chk("rst_mem_addr",  mm.mem_addr, 32'h0);
    chk("rst_mem_be",    {28'h0, mm.mem_be}, 32'h0);
    chk("rst_mem_wdata", mm.mem_wdata, 32'h0);
    rst_n = 1'b1;

    // lw with one-cycle memory latency: minimum turnaround.
    preload(32'h1004, 32'hDEAD_BEEF);
    send(OP_LW, 32'h1000, 16'h0004, 32'h0, 1, 0, 0);
    @(negedge clk);
    chk("lw_mem_req_n", {31'h0, mm.mem_req}, 32'h1);
    @(negedge clk);
    chk("lw_rsp_valid_n1", {31'h0, rq.rsp_valid}, 32'h1);
    chk("lw_rsp_const", rq.rsp_data, 32'hDEAD_BEEF);

    preload(32'h1000, 32'h8011_2233);
    send(OP_LB,  32'h1000, 16'h0003, 32'h0, 2, 0, 0);
    send(OP_LBU, 32'h1000, 16'h0003, 32'h0, 2, 0, 0);
    send(OP_SH,  32'h2000, 16'hFFFE, 32'h0000_ABCD, 1, 0, 0);
    send(OP_LH,  32'h0000_0000, 16'hFFFE, 32'h0, 3, 0, 0);

    // Misaligned word store and illegal opcode: immediate error, no access.
    send(OP_SW, 32'h3000, 16'h0002, 32'h1234_5678, 1, 0, 0);
    @(negedge clk);
    chk("sw_mis_rsp_valid", {31'h0, rq.rsp_valid}, 32'h1);
    chk("sw_mis_mem_req", {31'h0, mm.mem_req}, 32'h0);
    send(6'b000000, 32'h3000, 16'h0002, 32'h0, 1, 0, 0);
    @(negedge clk);
    chk("illegal_rsp_valid", {31'h0, rq.rsp_valid}, 32'h1);

    // Memory never acks: timeout after TMO cycles, then a stray ack.
    send(OP_LW, 32'h1000, 16'h0000, 32'h0, 0, 1, 0);
    send(OP_SB, 32'h1000, 16'h0001, 32'h0000_00A5, 0, 1, 0);
    send(OP_LW, 32'h1000, 16'h0000, 32'h0, 1, 0, 0);

    // Reset in WAIT: mem_req drops asynchronously and no response appears.
    send(OP_LW, 32'h1000, 16'h0008, 32'h0, 0, 1, 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wait_mem_req", {31'h0, mm.mem_req}, 32'h0);
    chk("rst_wait_ready", {31'h0, rq.req_ready}, 32'h1);
    repeat (3) begin
      @(negedge clk);
      chk("rst_wait_no_rsp", {31'h0, rq.rsp_valid}, 32'h0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'h0, rq.req_ready}, 32'h1);
    send(OP_LW, 32'h1000, 16'h0010, 32'h0, 1, 0, 0);

    // Randomized traffic over a small window so loads see earlier stores.
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 19);
      if (r < 16) op = ops[r % 8];
      else        op = 6'($urandom);
      if ($urandom_range(0, 7) == 0) base = $urandom;
      else                           base = 32'h1000 + $urandom_range(0, 63);
      if ($urandom_range(0, 7) == 0) off = 16'($urandom);
      else                           off = 16'($urandom_range(0, 31)) - 16'd16;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(op, base, off, $urandom, $urandom_range(1, 3), ($urandom_range(0, 9) == 0), 0);
    end

    guard = 0;
    while ((exp_rsp.size() != 0 || exp_txn.size() != 0) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    chk("drain_rsp", exp_rsp.size(), 32'h0);
    chk("drain_txn", exp_txn.size(), 32'h0);
    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_lsu.md
# mips_lsu

Load/store unit sitting directly upstream of the data memory in the MIPS datapath. It accepts one load or store request per transaction from the execute stage. It computes the effective address as base + sign-extended 16-bit offset and checks alignment. It drives a byte-enabled word request to data memory, waits for the memory acknowledge, then returns formatted load data (sign- or zero-extended) or a store completion to writeback.

## Interface
- `TIMEOUT`, default 16: max cycles `mem_req` is held without `mem_ack` before an error response; 0 disables the timeout.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept; request transfers when `req_valid & req_ready` at a rising edge.
- `opcode` in 6: MIPS primary opcode (lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011).
- `base` in 32: rs register value.
- `offset` in 16: immediate; sign-extended internally.
- `store_data` in 32: rt register value.
- `rsp_valid` out 1: one-cycle response strobe; no backpressure.
- `rsp_data` out 32: load result, 0 for stores, faulting effective address on error.
- `rsp_err` out 1: qualifies `rsp_valid`; misaligned, illegal opcode or timeout.
- `mem_req` out 1: memory access request, held until `mem_ack`.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: word-aligned byte address, with bits [1:0] = 00.
- `mem_be` out 4: byte enables; bit i selects `wdata`/`rdata` bits [8i+7:8i].
- `mem_wdata` out 32: lane-steered store data.
- `mem_ack` in 1: access complete; `mem_rdata` is valid in the same cycle for reads.
- `mem_rdata` in 32: read word.

## Operation
- Effective address `ea = base + {{16{offset[15]}},offset}`, modulo 2^32. Wrap-around is legal; no error.
- Little-endian lanes: byte at `ea[1:0]=k` is lane k.
- Byte enables: sb uses lane `ea[1:0]`. sh uses 0011 when `ea[1]`=0 and 1100 when `ea[1]`=1. sw uses 1111. Loads always use 1111.
- Store data is replicated across lanes:
  - sb: `{4{sd[7:0]}}`
  - sh: `{2{sd[15:0]}}`
  - sw: unchanged
- Loads extract the selected lane(s) from `mem_rdata`. lb/lh sign-extend the result; lbu/lhu zero-extend it.
- Misaligned accesses:
  - half-word access with `ea[0]`=1
  - word access with `ea[1:0]`≠0
  
  A misaligned request is not issued to memory. It produces an error response with `rsp_data=ea`.
- Illegal opcode: error response with `rsp_data=ea`. No memory access.
- FSM states:
  - IDLE: `req_ready`=1. On accept with an error → RESP. On accept otherwise → WAIT. The request is registered on accept.
  - WAIT: `mem_req`=1 with registered address, enables and data. On `mem_ack` → RESP, capturing formatted data. If the counter reaches TIMEOUT first → RESP with `rsp_err`=1, `rsp_data=ea`.
  - RESP: `rsp_valid`=1 for exactly one cycle → IDLE.
- Late `mem_ack` arriving outside WAIT is ignored.
- Reset values: state=IDLE, `req_ready`=1, and all other outputs 0. Reset mid-WAIT drops `mem_req` asynchronously, and no response is produced.

## Timing
- Request accepted at edge N. `mem_req` is high from N until the edge where `mem_ack` is sampled (edge M ≥ N+1).
- `rsp_valid` is high during the cycle M to M+1. `req_ready` returns at M+1.
- With `mem_ack` sampled at N+1, a load returns `rsp_valid` during the cycle N+1 to N+2, so minimum turnaround is 3 edges per request.
- Error requests (misaligned/illegal): `rsp_valid` during N to N+1, with no `mem_req` cycle.
- Timeout counter counts cycles spent in WAIT. It reaches TIMEOUT at the edge after TIMEOUT WAIT cycles without ack. It clears on entry to WAIT.
- No outputs are combinational from inputs; all are registered or decoded from state.

## Structure
- Package `mips_pkg` holds the opcode localparams (`OP_LB` … `OP_SW`) and the FSM state encoding (`ST_IDLE`, `ST_WAIT`, `ST_RESP`).
- Sub-module `mips_lsu_align` is combinational. Inputs are opcode, `ea[1:0]`, store data and read data. Outputs are `be`, steered `wdata`, extended load data and a `misaligned` flag.
- The top level holds the FSM, request registers, timeout counter and response registers.

## Test plan
- lw, base=0x1000, offset=0x0004, memory acks after 1 cycle with rdata=0xDEADBEEF → `mem_addr`=0x1004, `mem_be`=1111, `rsp_data`=0xDEADBEEF, `rsp_err`=0.
- lb/lbu at ea=0x1003 with rdata=0x80112233 → lb returns 0xFFFFFF80; lbu returns 0x00000080.
- sh, base=0x2000, offset=0xFFFE, `store_data`=0x0000ABCD → `mem_addr`=0x1FFC, `mem_be`=1100, `mem_wdata`=0xABCDABCD, `mem_we`=1.
- sw at ea=0x3002 → no `mem_req`, `rsp_valid`+`rsp_err` on the next cycle, `rsp_data`=0x00003002. Opcode 000000 gives the same error response.
- TIMEOUT=4 with memory never acking → `mem_req` high for 4 cycles then drops, error response with `rsp_data`=ea. A later `mem_ack` is ignored.
- `rst_n` asserted while in WAIT → `mem_req` drops immediately and no `rsp_valid` is produced. After release, `req_ready`=1 and the next lw completes normally.
